multi_ch_clock_gate: RTL and testbench

MULTI_CH_CLOCK_GATE -- requirements
Module: multi_ch_clock_gate

---
 rtl/multi_ch_clock_gate.sv | 97 +++++++++
 tb/tb_multi_ch_clock_gate.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_clock_gate.sv
// Multi-channel clock gate: each channel runs an OFF/WAKE/RUN/GATED FSM with optional
// idle-based auto-gating and drives its clock through a low-transparent enable latch.
module multi_ch_clock_gate #(
  parameter int N_CH     = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_CH-1:0]   i_ch_en,
  input  logic [N_CH-1:0]   i_auto_mode,
  input  logic [N_CH-1:0]   i_busy,
  input  logic [IDLE_W-1:0] i_idle_thresh,
  input  logic              i_test_en,
  output logic [N_CH-1:0]   o_clk,
  output logic [N_CH-1:0]   o_gated,
  output logic [N_CH-1:0]   o_ready
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    WAKE  = 2'd1,
    RUN   = 2'd2,
    GATED = 2'd3
  } state_e;

  localparam logic [3:0]        WakeLast = 4'(WAKE_CYC - 1);
  localparam logic [IDLE_W-1:0] IdleMax  = '1;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e            state_q, state_d;
    logic [3:0]        wakeCnt_q, wakeCnt_d;
    logic [IDLE_W-1:0] idleCnt_q, idleCnt_d, idleInc;
    logic              gated_q, ready_q;
    logic              rawEn, clkEn;

    // Disable always wins, then wake causes, then idle expiry; counters default to clear.
    always_comb begin
      state_d   = state_q;
      wakeCnt_d = '0;
      idleCnt_d = '0;
      idleInc   = (idleCnt_q == IdleMax) ? idleCnt_q : idleCnt_q + 1'b1;
      case (state_q)
        OFF: begin
          if (i_ch_en[c]) state_d = WAKE;
        end
        WAKE: begin
          if (!i_ch_en[c])                state_d = OFF;
          else if (wakeCnt_q >= WakeLast) state_d = RUN;
          else                            wakeCnt_d = wakeCnt_q + 1'b1;
        end
        RUN: begin
          if (!i_ch_en[c]) begin
            state_d = OFF;
          end else if (i_auto_mode[c] && !i_busy[c]) begin
            if ((i_idle_thresh != '0) && (idleInc >= i_idle_thresh)) state_d = GATED;
            else                                                     idleCnt_d = idleInc;
          end
        end
        GATED: begin
          if (!i_ch_en[c])                        state_d = OFF;
          else if (i_busy[c] || !i_auto_mode[c])  state_d = WAKE;
        end
        default: state_d = OFF;
      endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        state_q   <= OFF;
        wakeCnt_q <= '0;
        idleCnt_q <= '0;
        gated_q   <= 1'b1;
        ready_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        wakeCnt_q <= wakeCnt_d;
        idleCnt_q <= idleCnt_d;
        gated_q   <= (state_d == OFF) || (state_d == GATED);
        ready_q   <= (state_d == RUN);
      end
    end

    assign rawEn = (state_q == WAKE) || (state_q == RUN) || i_test_en;

    // Enable only changes while the clock is low, so the AND gate never emits a runt pulse.
    always_latch begin
      if (i_reset)     clkEn = 1'b0;
      else if (!i_clk) clkEn = rawEn;
    end

    assign o_clk[c]   = i_clk & clkEn;
    assign o_gated[c] = gated_q;
    assign o_ready[c] = ready_q;
  end

endmodule

// File: tb/tb_multi_ch_clock_gate.sv
// Bench for multi_ch_clock_gate: directed scenarios plus random traffic, all compared
// against a cycle-level behavioural model of each channel.
`timescale 1ns/1ps
module tb_multi_ch_clock_gate;
  localparam int N        = 4;
  localparam int IW       = 8;
  localparam int WC       = 2;
  localparam int IDLE_MAX = (1 << IW) - 1;
  localparam int M_OFF = 0, M_WAKE = 1, M_RUN = 2, M_GATED = 3;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic [N-1:0]  i_ch_en = '0;
  logic [N-1:0]  i_auto_mode = '0;
  logic [N-1:0]  i_busy = '0;
  logic [IW-1:0] i_idle_thresh = '0;
  logic          i_test_en = 1'b1;
  logic [N-1:0]  o_clk, o_gated, o_ready;

  always #5 i_clk = ~i_clk;

  multi_ch_clock_gate #(.N_CH(N), .IDLE_W(IW), .WAKE_CYC(WC)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ch_en(i_ch_en), .i_auto_mode(i_auto_mode),
    .i_busy(i_busy), .i_idle_thresh(i_idle_thresh), .i_test_en(i_test_en),
    .o_clk(o_clk), .o_gated(o_gated), .o_ready(o_ready)
  );

  int tests = 0, fails = 0, glitches = 0;
  int mSt[N], mWake[N], mIdle[N];
  logic [N-1:0] expLatch = '0;
  logic [N-1:0] prevClk = '0;

  // Gated clock may only rise on an i_clk rising edge (t%10==5) and fall on a falling edge or reset.
  always @(o_clk) begin
    for (int c = 0; c < N; c++) begin
      if (o_clk[c] && !prevClk[c] && (($time % 10) != 5)) glitches++;
      else if (!o_clk[c] && prevClk[c] && (($time % 10) != 0) && !i_reset) glitches++;
    end
    prevClk = o_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [N-1:0] expReady();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = (mSt[c] == M_RUN);
    return r;
  endfunction

  function automatic logic [N-1:0] expGated();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = (mSt[c] == M_OFF) || (mSt[c] == M_GATED);
    return r;
  endfunction

  function automatic logic [N-1:0] expRaw(input logic tst);
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = (mSt[c] == M_WAKE) || (mSt[c] == M_RUN) || tst;
    return r;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < N; c++) begin
      mSt[c] = M_OFF; mWake[c] = 0; mIdle[c] = 0;
    end
    expLatch = '0;
  endtask

  task automatic modelStep();
    for (int c = 0; c < N; c++) begin
      if (!i_ch_en[c]) begin
        mSt[c] = M_OFF; mIdle[c] = 0;
      end else if (mSt[c] == M_OFF) begin
        mSt[c] = M_WAKE; mWake[c] = WC;
      end else if (mSt[c] == M_WAKE) begin
        mWake[c]--;
        if (mWake[c] == 0) mSt[c] = M_RUN;
      end else if (mSt[c] == M_RUN) begin
        if (i_auto_mode[c] && !i_busy[c]) begin
          mIdle[c] = (mIdle[c] < IDLE_MAX) ? mIdle[c] + 1 : IDLE_MAX;
          if (i_idle_thresh != 0 && mIdle[c] >= int'(i_idle_thresh)) begin
            mSt[c] = M_GATED; mIdle[c] = 0;
          end
        end else begin
          mIdle[c] = 0;
        end
      end else if (i_busy[c] || !i_auto_mode[c]) begin
        mSt[c] = M_WAKE; mWake[c] = WC;
      end
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] en, input logic [N-1:0] au,
                               input logic [N-1:0] bz, input logic [IW-1:0] th,
                               input logic tst);
    @(negedge i_clk);
    i_ch_en = en; i_auto_mode = au; i_busy = bz; i_idle_thresh = th; i_test_en = tst;
    #1;
    expLatch = expRaw(tst);
    checkOutput("clk_low", 32'(o_clk), 32'd0);
    @(posedge i_clk);
    modelStep();
    #1;
    checkOutput("clk_high", 32'(o_clk), 32'(expLatch));
    checkOutput("ready", 32'(o_ready), 32'(expReady()));
    checkOutput("gated", 32'(o_gated), 32'(expGated()));
  endtask

  // Reset is asserted in the high phase so a running clock must drop at once.
  task automatic applyReset(input logic tst);
    @(posedge i_clk);
    #2;
    i_test_en = tst;
    i_reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_clk", 32'(o_clk), 32'd0);
    checkOutput("rst_gated", 32'(o_gated), 32'hF);
    checkOutput("rst_ready", 32'(o_ready), 32'd0);
    @(negedge i_clk);
    #2;
    checkOutput("rst_clk_low", 32'(o_clk), 32'd0);
    @(posedge i_clk);
    #2;
    checkOutput("rst_clk_high", 32'(o_clk), 32'd0);
    checkOutput("rst_gated_hold", 32'(o_gated), 32'hF);
    i_reset = 1'b0;
  endtask

  logic [N-1:0]  en, au, bz;
  logic [IW-1:0] th;
  logic          te;

  initial begin
    modelReset();
    repeat (2) @(posedge i_clk);
    #2;
    checkOutput("init_clk_test", 32'(o_clk), 32'd0);
    checkOutput("init_gated", 32'(o_gated), 32'hF);
    checkOutput("init_ready", 32'(o_ready), 32'd0);
    i_test_en = 1'b0;
    i_reset = 1'b0;

    en = '0; au = '0; bz = '0; th = '0; te = 1'b0;
    repeat (2) applyStimulus(en, au, bz, th, te);
    en = 4'b0001;
    applyStimulus(en, au, bz, th, te);
    checkOutput("en_k_ready", 32'(o_ready[0]), 32'd0);
    checkOutput("en_k_gated", 32'(o_gated[0]), 32'd0);
    checkOutput("en_k_clk", 32'(o_clk[0]), 32'd0);
    applyStimulus(en, au, bz, th, te);
    checkOutput("en_k1_clk", 32'(o_clk[0]), 32'd1);
    checkOutput("en_k1_ready", 32'(o_ready[0]), 32'd0);
    applyStimulus(en, au, bz, th, te);
    checkOutput("en_k2_ready", 32'(o_ready[0]), 32'd1);

    en = 4'b0011;
    repeat (3) applyStimulus(en, au, bz, th, te);
    au = 4'b0010; th = 8'd5;
    repeat (4) applyStimulus(en, au, bz, th, te);
    checkOutput("idle4_ready", 32'(o_ready[1]), 32'd1);
    applyStimulus(en, au, bz, th, te);
    checkOutput("idle5_gated", 32'(o_gated[1]), 32'd1);
    checkOutput("idle5_ready", 32'(o_ready[1]), 32'd0);
    repeat (2) applyStimulus(en, au, bz, th, te);
    checkOutput("gated_clk", 32'(o_clk[1]), 32'd0);

    bz = 4'b0010;
    applyStimulus(en, au, bz, th, te);
    checkOutput("busy_wake_gated", 32'(o_gated[1]), 32'd0);
    bz = '0;
    applyStimulus(en, au, bz, th, te);
    checkOutput("busy_wake_notready", 32'(o_ready[1]), 32'd0);
    applyStimulus(en, au, bz, th, te);
    checkOutput("busy_wake_ready", 32'(o_ready[1]), 32'd1);
    repeat (4) applyStimulus(en, au, bz, th, te);
    applyStimulus(en, au, 4'b0010, th, te);
    repeat (4) applyStimulus(en, au, bz, th, te);
    checkOutput("restart_ready", 32'(o_ready[1]), 32'd1);
    applyStimulus(en, au, bz, th, te);
    checkOutput("restart_gated", 32'(o_gated[1]), 32'd1);

    applyStimulus(4'b0001, au, 4'b0010, th, te);
    checkOutput("prio_gated", 32'(o_gated[1]), 32'd1);
    applyStimulus(4'b0001, au, bz, th, te);
    checkOutput("prio_off", 32'(o_gated[1]), 32'd1);

    en = 4'hF; au = 4'hF; bz = '0; th = '0;
    repeat (300) applyStimulus(en, au, bz, th, te);
    checkOutput("thr0_ready", 32'(o_ready), 32'hF);

    en = '0;
    repeat (2) applyStimulus(en, au, bz, th, te);
    te = 1'b1;
    repeat (2) begin
      applyStimulus(en, au, bz, th, te);
      checkOutput("test_clk", 32'(o_clk), 32'hF);
      checkOutput("test_gated", 32'(o_gated), 32'hF);
    end
    te = 1'b0;

    en = 4'hF; au = '0;
    repeat (4) applyStimulus(en, au, bz, th, te);
    applyReset(1'b1);
    applyStimulus(en, au, bz, th, te);
    applyReset(1'b0);

    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++) begin
        en[c] = ($urandom_range(7) != 0);
        bz[c] = ($urandom_range(3) == 0);
      end
      if ($urandom_range(15) == 0) au = N'($urandom);
      if ($urandom_range(49) == 0) th = IW'($urandom_range(7));
      te = ($urandom_range(31) == 0);
      if ($urandom_range(199) == 0) applyReset(1'($urandom));
      applyStimulus(en, au, bz, th, te);
    end

    checkOutput("glitches", 32'(glitches), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
